// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for the multi-cycle RV32I datapath (BEQ/BNE, illegal-opcode flag, instret).
// Define CTRL_JALR_EN to add the two-state JALR sequence; otherwise opcode 1100111 is illegal.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int INSTRET_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Zero,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  illegal_instr,
    output logic [INSTRET_W-1:0]  instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12
    } state_t;

    state_t                 r_state;
    state_t                 w_state;
    state_t                 w_next;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   w_retire;
    logic                   w_pcUpdate;
    logic                   w_branch;
    logic                   w_taken;
    logic                   w_adrSrc;
    logic                   w_memWrite;
    logic                   w_irWrite;
    logic                   w_regWrite;
    logic                   w_illegal;
    logic [1:0]             w_resultSrc;
    logic [1:0]             w_aluSrcA;
    logic [1:0]             w_aluSrcB;
    logic [1:0]             w_aluOp;
    logic [2:0]             w_aluCode;

    // While reset is held the outputs show FETCH decoding with every enable suppressed.
    assign w_state  = rst ? S_FETCH : r_state;
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                      (r_state == S_ALUWB) || (r_state == S_BRANCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcUpdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrSrc    = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_illegal   = 1'b0;
        w_resultSrc = 2'b00;
        w_aluSrcA   = 2'b00;
        w_aluSrcB   = 2'b00;
        w_aluOp     = 2'b00;
        case (w_state)
            S_FETCH: begin
                w_irWrite   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_resultSrc = 2'b10;
                w_pcUpdate  = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100011:             w_next = S_BRANCH;
`ifdef CTRL_JALR_EN
                    7'b1100111:             w_next = S_JALR1;
`endif
                    default:                w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrSrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultSrc = 2'b01;
                w_regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrSrc   = 1'b1;
                w_memWrite = 1'b1;
            end
            S_EXECR: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_aluOp   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: w_regWrite = 1'b1;
            S_JAL: begin
                w_aluSrcA  = 2'b01;
                w_aluSrcB  = 2'b10;
                w_pcUpdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BRANCH: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b01;
                w_branch  = 1'b1;
            end
            S_JALR1: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_next    = S_JALR2;
            end
            S_JALR2: begin
                w_aluSrcA  = 2'b01;
                w_aluSrcB  = 2'b10;
                w_pcUpdate = 1'b1;
                w_next     = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = ~Zero;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_aluCode = 3'b000;
        case (w_aluOp)
            2'b01: w_aluCode = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_aluCode = (op[5] & funct7) ? 3'b001 : 3'b000;
                    3'b010:  w_aluCode = 3'b101;
                    3'b110:  w_aluCode = 3'b011;
                    3'b111:  w_aluCode = 3'b010;
                    default: w_aluCode = 3'b000;
                endcase
            end
            default: w_aluCode = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite       = (w_pcUpdate | (w_branch & w_taken)) & ~rst;
    assign AdrSrc        = w_adrSrc;
    assign MemWrite      = w_memWrite & ~rst;
    assign IRWrite       = w_irWrite & ~rst;
    assign RegWrite      = w_regWrite & ~rst;
    assign illegal_instr = w_illegal & ~rst;
    assign ResultSrc     = w_resultSrc;
    assign ALUSrcA       = w_aluSrcA;
    assign ALUSrcB       = w_aluSrcB;
    assign ALUControl    = ALU_CTRL_W'(w_aluCode);
    assign instret       = r_instret;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-cycle control unit, for the multi-cycle RV32I datapath. The single shared memory, IR/OldPC/ALUOut/Data registers and one ALU are sequenced by a Moore FSM, so each instruction takes 3-5 cycles.
- Adds BNE alongside BEQ.
- Flags illegal opcodes.
- Keeps a retired-instruction counter.
- Supports optional JALR.

Parameters:
- ALU_CTRL_W, 3, width of ALUControl (min 3); codes are zero-extended.
- INSTRET_W, 32, width of the retired-instruction counter; wraps modulo 2^INSTRET_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Zero  in  1  ALU zero flag
- op  in  7  instruction opcode; op[5] is used as op5
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR/OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=const 4
- ImmSrc  out  2  immediate type: 00=I, 01=S, 10=B, 11=J
- ALUControl  out  ALU_CTRL_W  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset:
  - On a clk edge with rst=1: state<=FETCH, instret<=0.
  - While rst=1: PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are forced to 0; other outputs take FETCH values.
  - rst mid-instruction aborts it; no count, no write.
- Outputs are Moore, decoded from state. Exception: PCWrite = PCUpdate | (Branch & taken).
  - taken = Zero when funct3=000 (BEQ); ~Zero when funct3=001 (BNE); 0 for any other funct3.
- Any signal not listed for a state is 0.
- States and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - anything else -> FETCH with illegal_instr=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- ImmSrc is decoded combinationally from op: load/OP-IMM/JALR=00, store=01, branch=10, JAL=11, other=00.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if op5&funct7, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- instret increments by 1 on each transition from MEMWB, MEMWRITE, ALUWB or BRANCH to FETCH.
  - Illegal instructions do not increment it.
  - Increment wraps from all-ones to 0.
- Latencies in cycles: branch 3, R/I/store/JAL 4, load 5, illegal 2.
- Undefined state encodings -> FETCH on the next edge.

Optional Feature:
- Macro: CTRL_JALR_EN.
- Defined: op 1100111 in DECODE -> JALR1 -> JALR2 -> ALUWB.
  - JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut=rs1+imm).
  - JALR2: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 (PC<=target; ALUOut=OldPC+4).
  - ALUWB writes OldPC+4 to rd. Latency 5 cycles; retires normally.
- Undefined: 1100111 is illegal (illegal_instr pulse, no retire).

Test Plan:
- Hold rst=1 for 2 cycles with op=0110011 -> all write enables 0 and instret=0; after release, the first cycle is FETCH (IRWrite=1, PCWrite=1).
- lw (op=0000011) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; instret goes 0->1.
- sw then R-type sub (funct3=000, funct7=1) -> MemWrite=1 only in MEMWRITE; ALUControl=001 in EXECR; instret=2.
- Branches:
  - BEQ with Zero=1 -> PCWrite=1 in BRANCH.
  - BNE with Zero=1 -> PCWrite=0.
  - BNE with Zero=0 -> PCWrite=1.
  - funct3=100 -> PCWrite=0.
  - Each branch retires.
- op=1111111 -> illegal_instr=1 for exactly one cycle in DECODE, then FETCH; instret unchanged.
- With INSTRET_W=4, preload via 15 retirements then one addi -> instret wraps 15->0.
- JALR: with CTRL_JALR_EN -> 5-cycle sequence, PCWrite=1 in JALR2. Without it -> illegal pulse.
